// File: rtl/game_pkg.sv
// Shared types and constants for the barrier game controller.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_APPROACH,
        S_ARMED,
        S_RESOLVE,
        S_OVER
    } state_t;

    localparam int SCORE_W = 16;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    localparam int CNT_W = 8;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 map to bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/barrier_ctrl_if.sv
// Video-side and game-side signals of the barrier controller.
interface barrier_ctrl_if;
    import game_pkg::*;

    logic               i_v_sync;
    logic               i_game_en;
    logic               i_barrier_hit;
    logic               i_player_hit;
    logic               i_in_position;
    logic               o_barrier_active;
    logic               o_collision;
    logic               o_dodge;
    logic [1:0]         o_lives;
    logic [SCORE_W-1:0] o_score;
    logic               o_game_over;

    modport master (
        output i_v_sync, i_game_en, i_barrier_hit,
        output i_player_hit, i_in_position,
        input  o_barrier_active, o_collision, o_dodge,
        input  o_lives, o_score, o_game_over
    );

    modport slave (
        input  i_v_sync, i_game_en, i_barrier_hit,
        input  i_player_hit, i_in_position,
        output o_barrier_active, o_collision, o_dodge,
        output o_lives, o_score, o_game_over
    );

endinterface

// File: rtl/vsync_tick.sv
// Two-flop v_sync synchronizer with registered rising-edge pulse.
module vsync_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic v_sync,
    output logic tick
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], v_sync};
            tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/barrier_ctrl.sv
// Barrier strike FSM: cooldown, approach, strike window, scoring.
module barrier_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int COOLDOWN_MIN   = 30,
    parameter int TIMEOUT_FRAMES = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    barrier_ctrl_if.slave bus
);

    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TIMEOUT_FRAMES - 1);

    state_t             state, state_nx;
    logic               tick;
    logic [7:0]         lfsr;
    logic [CNT_W-1:0]   cool_cnt, cool_nx;
    logic [CNT_W-1:0]   appr_cnt, appr_nx;
    logic [CNT_W-1:0]   cool_load;
    logic               overlap, overlap_nx;
    logic [1:0]         lives, lives_nx, lives_dec;
    logic [SCORE_W-1:0] score, score_nx;
    logic               en_q;
    logic               en;
    logic               active;

    vsync_tick u_tick (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .v_sync (bus.i_v_sync),
        .tick   (tick)
    );

    assign en        = bus.i_game_en;
    assign cool_load = CNT_W'(COOLDOWN_MIN) + CNT_W'(lfsr[3:0]);
    assign lives_dec = (lives == 2'd0) ? 2'd0 : lives - 2'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            lfsr     <= LFSR_SEED;
            cool_cnt <= '0;
            appr_cnt <= '0;
            overlap  <= 1'b0;
            lives    <= LIVES_RST;
            score    <= '0;
            en_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            cool_cnt <= cool_nx;
            appr_cnt <= appr_nx;
            overlap  <= overlap_nx;
            lives    <= lives_nx;
            score    <= score_nx;
            en_q     <= en;
            if (tick)
                lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        state_nx   = state;
        cool_nx    = cool_cnt;
        appr_nx    = appr_cnt;
        overlap_nx = overlap;
        lives_nx   = lives;
        score_nx   = score;
        unique case (state)
            S_IDLE: begin
                if (tick && en) begin
                    state_nx = S_COOLDOWN;
                    cool_nx  = cool_load;
                end
            end
            S_COOLDOWN: begin
                if (tick) begin
                    if (cool_cnt == '0) begin
                        state_nx = S_APPROACH;
                        appr_nx  = '0;
                    end else begin
                        cool_nx = cool_cnt - CNT_W'(1);
                    end
                end
            end
            S_APPROACH: begin
                if (tick) begin
                    if (bus.i_in_position) begin
                        state_nx   = S_ARMED;
                        overlap_nx = 1'b0;
                    end else if (appr_cnt == TO_LAST) begin
                        state_nx = S_COOLDOWN;
                        cool_nx  = cool_load;
                    end else begin
                        appr_nx = appr_cnt + CNT_W'(1);
                    end
                end
            end
            S_ARMED: begin
                if (bus.i_barrier_hit && bus.i_player_hit && active)
                    overlap_nx = 1'b1;
                if (tick)
                    state_nx = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (overlap)
                    lives_nx = lives_dec;
                else if (score != SCORE_MAX)
                    score_nx = score + SCORE_W'(1);
                if (lives_nx == 2'd0) begin
                    state_nx = S_OVER;
                end else begin
                    state_nx = S_COOLDOWN;
                    cool_nx  = cool_load;
                end
            end
            S_OVER: begin
                if (en && !en_q) begin
                    state_nx = S_IDLE;
                    lives_nx = LIVES_RST;
                    score_nx = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A strike that just emptied the lives still ends in OVER.
        if (!en && state != S_OVER && state_nx != S_OVER)
            state_nx = S_IDLE;
    end

    assign active = (state == S_APPROACH) || (state == S_ARMED);

    assign bus.o_barrier_active = active;
    assign bus.o_collision      = (state == S_RESOLVE) && overlap;
    assign bus.o_dodge          = (state == S_RESOLVE) && !overlap;
    assign bus.o_lives          = lives;
    assign bus.o_score          = score;
    assign bus.o_game_over      = (lives == 2'd0);

endmodule
